// File: rtl/kalman_axi_pkg.sv
// Shared AXI4 constants and helpers for the Kalman DDR4 loader and result writer.
//   LANES_PER_BEAT / BYTES_PER_BEAT : 512-bit data beat split into 64-bit words
//   AXI_SIZE_64B / AXI_BURST_INCR / AXI_RESP_OKAY : AXI4 field encodings
//   beats(words) : number of 8-word beats needed to carry 'words' words
//   loader_state_e / burst_state_e : FSM encodings used by the read path
package kalman_axi_pkg;

  localparam int unsigned LANES_PER_BEAT = 8;
  localparam int unsigned BYTES_PER_BEAT = 64;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int unsigned beats(input int unsigned words);
    return (words + LANES_PER_BEAT - 1) / LANES_PER_BEAT;
  endfunction

  typedef enum logic [2:0] {
    LdIdle, LdArX, LdRX, LdArP, LdRP, LdArZ, LdRZ, LdDone
  } loader_state_e;

  typedef enum logic [1:0] {
    BcIdle, BcAddr, BcData
  } burst_state_e;

endpackage

// File: rtl/axi_rd_burst_ctrl.sv
// Single-outstanding AXI4 read burst engine.
//   clk, rst_n           : clock, async active-low reset
//   start, addr, len     : launch a burst (only while idle or on the burst_done cycle)
//   axi_ar*              : registered read-address channel, held stable until arready
//   axi_r* (minus data)  : read-data handshake; rready is high only while collecting beats
//   ar_hs                : address handshake this cycle
//   beat_valid, beat_idx : beat accepted this cycle and its index within the burst
//   burst_done           : beat number 'len' accepted this cycle
//   err                  : accepted beat has a bad response or misplaced/missing rlast
module axi_rd_burst_ctrl
  import kalman_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic        ar_hs,
  output logic        beat_valid,
  output logic [7:0]  beat_idx,
  output logic        burst_done,
  output logic        err
);

  burst_state_e state_q, state_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic         arvalid_q, arvalid_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         last_beat;

  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arsize  = AXI_SIZE_64B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arvalid = arvalid_q;

  always_comb begin
    ar_hs      = arvalid_q & axi_arready;
    axi_rready = (state_q == BcData);
    beat_valid = axi_rvalid & axi_rready;
    beat_idx   = cnt_q;
    // Termination follows the beat counter; rlast is only cross-checked.
    last_beat  = (cnt_q == arlen_q);
    burst_done = beat_valid & last_beat;
    err        = beat_valid & ((axi_rlast != last_beat) | (axi_rresp != AXI_RESP_OKAY));

    state_d   = state_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      BcIdle: ;
      BcAddr: begin
        if (ar_hs) begin
          state_d   = BcData;
          arvalid_d = 1'b0;
          cnt_d     = '0;
        end
      end
      BcData: begin
        if (beat_valid) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = BcIdle;
        end
      end
      default: state_d = BcIdle;
    endcase

    // The next burst may be chained on the cycle the previous one completes.
    if (start) begin
      state_d   = BcAddr;
      arvalid_d = 1'b1;
      araddr_d  = addr;
      arlen_d   = len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BcIdle;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr4_state_loader.sv
// Loads the Kalman initial state X, covariance P and measurement frame Z from DDR4.
//   clk, rst_n                   : clock, async active-low reset
//   read_en                      : level start request; must drop before the next load
//   load_state                   : 1 = X, P then Z; 0 = Z only (sampled at start)
//   z_index                      : Z frame number (sampled at start)
//   X_init_out/P_init_out/Z_out  : unpacked 64-bit words, updated in place per beat
//   load_done                    : one-cycle pulse after the final Z beat
//   busy                         : high while a load sequence is in flight
//   rd_err                       : sticky AXI response/rlast error
//   axi_ar* / axi_r*             : 512-bit AXI4 read port
module ddr4_state_loader
  import kalman_axi_pkg::*;
#(
  parameter int unsigned STATE_DIM        = 12,
  parameter int unsigned MEASURE_DIM      = 6,
  parameter logic [31:0] ADDR_X_INIT_BASE = 32'h0010_0000,
  parameter logic [31:0] ADDR_P_INIT_BASE = 32'h0020_0000,
  parameter logic [31:0] ADDR_Z_BASE      = 32'h0030_0000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   read_en,
  input  logic                                   load_state,
  input  logic [15:0]                            z_index,
  output logic [STATE_DIM-1:0][63:0]             X_init_out,
  output logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0] P_init_out,
  output logic [MEASURE_DIM-1:0][63:0]           Z_out,
  output logic                                   load_done,
  output logic                                   busy,
  output logic                                   rd_err,
  output logic [31:0]                            axi_araddr,
  output logic [7:0]                             axi_arlen,
  output logic [2:0]                             axi_arsize,
  output logic [1:0]                             axi_arburst,
  output logic                                   axi_arvalid,
  input  logic                                   axi_arready,
  input  logic [511:0]                           axi_rdata,
  input  logic [1:0]                             axi_rresp,
  input  logic                                   axi_rlast,
  input  logic                                   axi_rvalid,
  output logic                                   axi_rready
);

  localparam int unsigned X_WORDS = STATE_DIM;
  localparam int unsigned P_WORDS = STATE_DIM * STATE_DIM;
  localparam int unsigned Z_WORDS = MEASURE_DIM;
  localparam int unsigned X_BEATS = beats(X_WORDS);
  localparam int unsigned P_BEATS = beats(P_WORDS);
  localparam int unsigned Z_BEATS = beats(Z_WORDS);
  localparam logic [7:0]  X_ARLEN = 8'(X_BEATS - 1);
  localparam logic [7:0]  P_ARLEN = 8'(P_BEATS - 1);
  localparam logic [7:0]  Z_ARLEN = 8'(Z_BEATS - 1);

  // Frame offset wraps modulo 2^32.
  function automatic logic [31:0] z_addr(input logic [15:0] idx);
    return ADDR_Z_BASE + 32'(idx) * 32'(Z_BEATS * BYTES_PER_BEAT);
  endfunction

  loader_state_e state_q, state_d;
  logic [15:0]   z_index_q, z_index_d;
  logic          load_done_q, load_done_d;
  logic          rd_err_q;

  logic          start;
  logic [31:0]   req_addr;
  logic [7:0]    req_len;
  logic          ar_hs, beat_valid, burst_done, beat_err;
  logic [7:0]    beat_idx;

  axi_rd_burst_ctrl u_burst (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .addr        (req_addr),
    .len         (req_len),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .ar_hs       (ar_hs),
    .beat_valid  (beat_valid),
    .beat_idx    (beat_idx),
    .burst_done  (burst_done),
    .err         (beat_err)
  );

  always_comb begin
    state_d     = state_q;
    z_index_d   = z_index_q;
    start       = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    load_done_d = 1'b0;

    unique case (state_q)
      LdIdle: begin
        if (read_en) begin
          start     = 1'b1;
          z_index_d = z_index;
          if (load_state) begin
            state_d  = LdArX;
            req_addr = ADDR_X_INIT_BASE;
            req_len  = X_ARLEN;
          end else begin
            state_d  = LdArZ;
            req_addr = z_addr(z_index);
            req_len  = Z_ARLEN;
          end
        end
      end
      LdArX: if (ar_hs) state_d = LdRX;
      LdRX: begin
        if (burst_done) begin
          state_d  = LdArP;
          start    = 1'b1;
          req_addr = ADDR_P_INIT_BASE;
          req_len  = P_ARLEN;
        end
      end
      LdArP: if (ar_hs) state_d = LdRP;
      LdRP: begin
        if (burst_done) begin
          state_d  = LdArZ;
          start    = 1'b1;
          req_addr = z_addr(z_index_q);
          req_len  = Z_ARLEN;
        end
      end
      LdArZ: if (ar_hs) state_d = LdRZ;
      LdRZ: begin
        if (burst_done) begin
          state_d     = LdDone;
          load_done_d = 1'b1;
        end
      end
      // Hold here until read_en drops so a level request cannot retrigger.
      LdDone: if (!read_en) state_d = LdIdle;
      default: state_d = LdIdle;
    endcase
  end

  assign busy      = (state_q != LdIdle) && (state_q != LdDone);
  assign load_done = load_done_q;
  assign rd_err    = rd_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LdIdle;
      z_index_q   <= '0;
      load_done_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_index_q   <= z_index_d;
      load_done_q <= load_done_d;
      rd_err_q    <= rd_err_q | beat_err;
    end
  end

  // Each word has a fixed (beat, lane) source; lanes past the word count are never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_init_out <= '0;
      P_init_out <= '0;
      Z_out      <= '0;
    end else if (beat_valid) begin
      if (state_q == LdRX) begin
        for (int unsigned i = 0; i < X_WORDS; i++) begin
          if (32'(beat_idx) == i / LANES_PER_BEAT) begin
            X_init_out[i] <= axi_rdata[(i % LANES_PER_BEAT) * 64 +: 64];
          end
        end
      end
      if (state_q == LdRP) begin
        for (int unsigned r = 0; r < STATE_DIM; r++) begin
          for (int unsigned c = 0; c < STATE_DIM; c++) begin
            if (32'(beat_idx) == (r * STATE_DIM + c) / LANES_PER_BEAT) begin
              P_init_out[r][c] <= axi_rdata[((r * STATE_DIM + c) % LANES_PER_BEAT) * 64 +: 64];
            end
          end
        end
      end
      if (state_q == LdRZ) begin
        for (int unsigned k = 0; k < Z_WORDS; k++) begin
          if (32'(beat_idx) == k / LANES_PER_BEAT) begin
            Z_out[k] <= axi_rdata[(k % LANES_PER_BEAT) * 64 +: 64];
          end
        end
      end
    end
  end

endmodule
